// File: rtl/program_loader.sv
// Byte-stream program loader: parses SYNC/N/data/checksum frames, writes 32-bit
// big-endian words to instruction memory from address 0 and holds the CPU until a good load.
module program_loader #(
  parameter int         INSTRUCTION_WIDTH = 32,
  parameter int         PC_WIDTH          = 8,
  parameter logic [7:0] SYNC_BYTE         = 8'hA5,
  parameter int         TIMEOUT_CYCLES    = 100000
) (
  input  logic                         clock,
  input  logic                         isResetN,
  input  logic [7:0]                   byteData,
  input  logic                         byteValid,
  output logic                         byteReady,
  output logic                         memWriteEnable,
  output logic [PC_WIDTH-1:0]          memWriteAddress,
  output logic [INSTRUCTION_WIDTH-1:0] memWriteData,
  output logic                         cpuHold,
  output logic                         loadDone,
  output logic                         loadError
);

  // Largest word count that fits the address space without wrapping.
  localparam int MAX_WORDS = (PC_WIDTH < 8) ? (1 << PC_WIDTH) : 256;
  localparam int TO_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, COUNT, DATA, WRITE, CHECK, DONE, ERROR} state_t;

  state_t                       state_reg, state_next;
  logic                         ready_reg;
  logic [INSTRUCTION_WIDTH-1:0] asm_reg, asm_next;
  logic [INSTRUCTION_WIDTH-1:0] wdata_reg, wdata_next;
  logic [PC_WIDTH-1:0]          waddr_reg, waddr_next;
  logic [PC_WIDTH-1:0]          addr_reg, addr_next;
  logic [7:0]                   count_reg, count_next;
  logic [7:0]                   words_reg, words_next;
  logic [1:0]                   idx_reg, idx_next;
  logic [7:0]                   csum_reg, csum_next;
  logic [TO_W-1:0]              timeout_reg, timeout_next;

  logic accept;
  logic in_frame;

  assign byteReady       = ready_reg && (state_reg != WRITE);
  assign accept          = byteValid && byteReady;
  assign in_frame        = (state_reg == COUNT) || (state_reg == DATA) || (state_reg == CHECK);
  assign memWriteEnable  = (state_reg == WRITE);
  assign memWriteAddress = waddr_reg;
  assign memWriteData    = wdata_reg;
  assign loadDone        = (state_reg == DONE);
  assign loadError       = (state_reg == ERROR);
  assign cpuHold         = (state_reg != IDLE) && (state_reg != DONE);

  always_ff @(posedge clock or negedge isResetN) begin
    if (!isResetN) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b0;
      asm_reg     <= '0;
      wdata_reg   <= '0;
      waddr_reg   <= '0;
      addr_reg    <= '0;
      count_reg   <= '0;
      words_reg   <= '0;
      idx_reg     <= '0;
      csum_reg    <= '0;
      timeout_reg <= '0;
    end else begin
      state_reg   <= state_next;
      ready_reg   <= 1'b1;
      asm_reg     <= asm_next;
      wdata_reg   <= wdata_next;
      waddr_reg   <= waddr_next;
      addr_reg    <= addr_next;
      count_reg   <= count_next;
      words_reg   <= words_next;
      idx_reg     <= idx_next;
      csum_reg    <= csum_next;
      timeout_reg <= timeout_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    asm_next     = asm_reg;
    wdata_next   = wdata_reg;
    waddr_next   = waddr_reg;
    addr_next    = addr_reg;
    count_next   = count_reg;
    words_next   = words_reg;
    idx_next     = idx_reg;
    csum_next    = csum_reg;
    timeout_next = '0;

    case (state_reg)
      IDLE, DONE, ERROR: begin
        if (accept && byteData == SYNC_BYTE) begin
          state_next = COUNT;
          addr_next  = '0;
          words_next = '0;
          idx_next   = '0;
          csum_next  = '0;
        end
      end
      COUNT: begin
        if (accept) begin
          if (byteData == 8'd0 || int'(byteData) > MAX_WORDS) begin
            state_next = ERROR;
          end else begin
            count_next = byteData;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (accept) begin
          asm_next  = {asm_reg[INSTRUCTION_WIDTH-9:0], byteData};
          csum_next = csum_reg ^ byteData;
          idx_next  = idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            wdata_next = {asm_reg[INSTRUCTION_WIDTH-9:0], byteData};
            waddr_next = addr_reg;
            state_next = WRITE;
          end
        end
      end
      WRITE: begin
        addr_next  = addr_reg + PC_WIDTH'(1);
        words_next = words_reg + 8'd1;
        state_next = (({1'b0, words_reg} + 9'd1) == {1'b0, count_reg}) ? CHECK : DATA;
      end
      CHECK: begin
        if (accept) begin
          state_next = (byteData == csum_reg) ? DONE : ERROR;
        end
      end
      default: state_next = IDLE;
    endcase

    // Idle-gap watchdog inside a frame; any accepted byte restarts it.
    if (TIMEOUT_CYCLES != 0 && in_frame && !accept) begin
      if (timeout_reg == TO_LAST) begin
        state_next = ERROR;
      end else begin
        timeout_next = timeout_reg + TO_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: table of per-byte vectors plus hand-written
// sequences for timeout, continuous valid, and mid-frame reset.
module tb_program_loader;

  logic        clock = 1'b0;
  logic        isResetN = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWriteEnable;
  logic [7:0]  memWriteAddress;
  logic [31:0] memWriteData;
  logic        cpuHold;
  logic        loadDone;
  logic        loadError;

  int checks = 0;
  int failures = 0;
  int we_cycles = 0;

  program_loader #(
    .INSTRUCTION_WIDTH(32),
    .PC_WIDTH(8),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock),
    .isResetN(isResetN),
    .byteData(byteData),
    .byteValid(byteValid),
    .byteReady(byteReady),
    .memWriteEnable(memWriteEnable),
    .memWriteAddress(memWriteAddress),
    .memWriteData(memWriteData),
    .cpuHold(cpuHold),
    .loadDone(loadDone),
    .loadError(loadError)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (memWriteEnable) we_cycles++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  data;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] word;
    bit          hold;
    bit          done;
    bit          err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present a byte, wait (bounded) for byteReady, return #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input bit keep_valid);
    int n = 0;
    @(negedge clock);
    byteData  = d;
    byteValid = 1'b1;
    while (!byteReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("ready_wait", {31'd0, byteReady}, 32'd1);
    @(posedge clock);
    #1;
    if (!keep_valid) byteValid = 1'b0;
  endtask

  function automatic vec_t v(input logic [7:0] d, input bit h, input bit dn, input bit e);
    vec_t r;
    r = '{d, 1'b0, 8'h00, 32'h0, h, dn, e};
    return r;
  endfunction

  function automatic vec_t w(input logic [7:0] d, input logic [7:0] a, input logic [31:0] wd);
    vec_t r;
    r = '{d, 1'b1, a, wd, 1'b1, 1'b0, 1'b0};
    return r;
  endfunction

  initial begin
    logic [7:0] cont_bytes[11];
    logic [7:0] b;

    // Frame 1: good load, XOR of 11..88 is 88.
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'h02, 1, 0, 0));
    vecs.push_back(v(8'h11, 1, 0, 0));
    vecs.push_back(v(8'h22, 1, 0, 0));
    vecs.push_back(v(8'h33, 1, 0, 0));
    vecs.push_back(w(8'h44, 8'd0, 32'h11223344));
    vecs.push_back(v(8'h55, 1, 0, 0));
    vecs.push_back(v(8'h66, 1, 0, 0));
    vecs.push_back(v(8'h77, 1, 0, 0));
    vecs.push_back(w(8'h88, 8'd1, 32'h55667788));
    vecs.push_back(v(8'h88, 0, 1, 0));
    vecs.push_back(v(8'h77, 0, 1, 0));
    // Frame 2: same data, bad checksum.
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'h02, 1, 0, 0));
    vecs.push_back(v(8'h11, 1, 0, 0));
    vecs.push_back(v(8'h22, 1, 0, 0));
    vecs.push_back(v(8'h33, 1, 0, 0));
    vecs.push_back(w(8'h44, 8'd0, 32'h11223344));
    vecs.push_back(v(8'h55, 1, 0, 0));
    vecs.push_back(v(8'h66, 1, 0, 0));
    vecs.push_back(v(8'h77, 1, 0, 0));
    vecs.push_back(w(8'h88, 8'd1, 32'h55667788));
    vecs.push_back(v(8'hCD, 1, 0, 1));
    vecs.push_back(v(8'h3C, 1, 0, 1));
    // Frame 3: zero count.
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'h00, 1, 0, 1));
    // Frame 4: SYNC values inside the frame are plain data.
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'h01, 1, 0, 0));
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(v(8'hA5, 1, 0, 0));
    vecs.push_back(w(8'hA5, 8'd0, 32'hA5A5A5A5));
    vecs.push_back(v(8'h00, 0, 1, 0));

    // Reset state.
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'd0, byteReady}, 32'd0);
    chk("rst_we", {31'd0, memWriteEnable}, 32'd0);
    chk("rst_addr", {24'd0, memWriteAddress}, 32'd0);
    chk("rst_data", memWriteData, 32'd0);
    chk("rst_flags", {29'd0, cpuHold, loadDone, loadError}, 32'd0);
    isResetN = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      send_byte(vecs[i].data, 1'b0);
      $display("vec %0d byte=%h we=%b addr=%h data=%h hold=%b done=%b err=%b",
               i, vecs[i].data, memWriteEnable, memWriteAddress, memWriteData,
               cpuHold, loadDone, loadError);
      chk($sformatf("vec%0d_we", i), {31'd0, memWriteEnable}, {31'd0, vecs[i].we});
      if (vecs[i].we) begin
        chk($sformatf("vec%0d_addr", i), {24'd0, memWriteAddress}, {24'd0, vecs[i].addr});
        chk($sformatf("vec%0d_data", i), memWriteData, vecs[i].word);
        chk($sformatf("vec%0d_ready_low", i), {31'd0, byteReady}, 32'd0);
      end
      chk($sformatf("vec%0d_flags", i), {29'd0, cpuHold, loadDone, loadError},
          {29'd0, vecs[i].hold, vecs[i].done, vecs[i].err});
    end
    repeat (2) @(negedge clock);
    chk("strobe_cycles", we_cycles, 32'd5);

    // Timeout: ERROR exactly 10 cycles after the last accepted byte.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    repeat (9) @(posedge clock);
    #1;
    $display("timeout +9 err=%b hold=%b", loadError, cpuHold);
    chk("timeout_early", {30'd0, cpuHold, loadError}, 32'b10);
    @(posedge clock);
    #1;
    $display("timeout +10 err=%b hold=%b", loadError, cpuHold);
    chk("timeout_hit", {30'd0, cpuHold, loadError}, 32'b11);

    // Continuous byteValid, restart from ERROR, two words; checksum 26.
    cont_bytes = '{8'hA5, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h26};
    for (int i = 0; i < 11; i++) begin
      b = cont_bytes[i];
      send_byte(b, 1'b1);
      $display("cont %0d byte=%h we=%b addr=%h data=%h", i, b, memWriteEnable, memWriteAddress, memWriteData);
      if (i == 5 || i == 9) begin
        chk($sformatf("cont%0d_we", i), {31'd0, memWriteEnable}, 32'd1);
        chk($sformatf("cont%0d_ready_low", i), {31'd0, byteReady}, 32'd0);
        chk($sformatf("cont%0d_addr", i), {24'd0, memWriteAddress}, (i == 5) ? 32'd0 : 32'd1);
        chk($sformatf("cont%0d_data", i), memWriteData, (i == 5) ? 32'hDEADBEEF : 32'h01020304);
      end
    end
    byteValid = 1'b0;
    chk("cont_flags", {29'd0, cpuHold, loadDone, loadError}, 32'b010);

    // Asynchronous reset mid-DATA, then a fresh load; checksum 08.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    chk("pre_reset_hold", {31'd0, cpuHold}, 32'd1);
    #2;
    isResetN = 1'b0;
    #1;
    $display("reset asserted ready=%b hold=%b addr=%h data=%h", byteReady, cpuHold, memWriteAddress, memWriteData);
    chk("mid_rst_ctrl", {27'd0, byteReady, memWriteEnable, cpuHold, loadDone, loadError}, 32'd0);
    chk("mid_rst_addr", {24'd0, memWriteAddress}, 32'd0);
    chk("mid_rst_data", memWriteData, 32'd0);
    @(negedge clock);
    isResetN = 1'b1;
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    send_byte(8'h78, 1'b0);
    $display("post-reset write we=%b addr=%h data=%h", memWriteEnable, memWriteAddress, memWriteData);
    chk("post_rst_we", {31'd0, memWriteEnable}, 32'd1);
    chk("post_rst_addr", {24'd0, memWriteAddress}, 32'd0);
    chk("post_rst_data", memWriteData, 32'h12345678);
    send_byte(8'h08, 1'b0);
    chk("post_rst_flags", {29'd0, cpuHold, loadDone, loadError}, 32'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
